// File: rtl/sqrt_pkg.sv
// Shared types and default widths for the restoring square-root datapath.
package sqrt_pkg;

    localparam int unsigned DEFAULT_ROOT_W = 16;
    localparam int unsigned RAD_W          = 2 * DEFAULT_ROOT_W;
    localparam int unsigned REM_W          = DEFAULT_ROOT_W + 1;
    localparam int unsigned TRIAL_W        = DEFAULT_ROOT_W + 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/sqrt_trial_step.sv
// One combinational restoring-sqrt iteration: shift in two radicand bits and
// try subtracting (root<<2)|1 from the partial remainder.
module sqrt_trial_step #(
    parameter int unsigned ROOT_W = sqrt_pkg::DEFAULT_ROOT_W
) (
    input  logic [ROOT_W+1:0] rem,
    input  logic [ROOT_W-1:0] root,
    input  logic [1:0]        bits,
    output logic [ROOT_W+1:0] rem_next,
    output logic [ROOT_W-1:0] root_next
);

    localparam int unsigned TrialW = ROOT_W + 2;

    logic [TrialW-1:0] r_shift;
    logic [TrialW-1:0] trial;

    always_comb begin
        // Remainder never exceeds 2*root, so the two dropped top bits are always zero.
        r_shift = TrialW'({rem, bits});
        trial   = {root, 2'b01};
        if (r_shift >= trial) begin
            rem_next  = r_shift - trial;
            root_next = ROOT_W'({root, 1'b1});
        end else begin
            rem_next  = r_shift;
            root_next = ROOT_W'({root, 1'b0});
        end
    end

endmodule

// File: rtl/sqrt_restoring_seq.sv
// Sequential restoring integer square root, one root bit per clock, valid/ready on both sides.
// Define SQRT_ROUND_EN to round root_o to nearest (saturating); rem_o stays the floor remainder.
module sqrt_restoring_seq
    import sqrt_pkg::*;
#(
    parameter int unsigned ROOT_W = DEFAULT_ROOT_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*ROOT_W-1:0] rad_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ROOT_W-1:0]   root_o,
    output logic [ROOT_W:0]     rem_o
);

    localparam int unsigned RadW   = 2 * ROOT_W;
    localparam int unsigned RemW   = ROOT_W + 1;
    localparam int unsigned TrialW = ROOT_W + 2;
    localparam int unsigned CntW   = $clog2(ROOT_W);

    state_e            state;
    logic [RadW-1:0]   rad;
    logic [TrialW-1:0] rem;
    logic [TrialW-1:0] rem_next;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W-1:0] root_next;
    logic [ROOT_W-1:0] root_final;
    logic [CntW-1:0]   cnt;

    sqrt_trial_step #(
        .ROOT_W (ROOT_W)
    ) u_step (
        .rem       (rem),
        .root      (root),
        .bits      (rad[RadW-1 -: 2]),
        .rem_next  (rem_next),
        .root_next (root_next)
    );

`ifdef SQRT_ROUND_EN
    // Round up when the remainder exceeds the floor root; never wrap past all-ones.
    always_comb begin
        root_final = root_next;
        if ((rem_next > TrialW'(root_next)) && (root_next != '1)) begin
            root_final = root_next + ROOT_W'(1);
        end
    end
`else
    assign root_final = root_next;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= StIdle;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            root_o      <= '0;
            rem_o       <= '0;
            rad         <= '0;
            rem         <= '0;
            root        <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid_i) begin
                        rad        <= rad_i;
                        rem        <= '0;
                        root       <= '0;
                        cnt        <= CntW'(ROOT_W - 1);
                        in_ready_o <= 1'b0;
                        state      <= StCalc;
                    end
                end
                StCalc: begin
                    rad  <= rad << 2;
                    rem  <= rem_next;
                    root <= root_next;
                    if (cnt == '0) begin
                        root_o      <= root_final;
                        rem_o       <= RemW'(rem_next);
                        out_valid_o <= 1'b1;
                        state       <= StDone;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: begin
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    state       <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_restoring_seq.sv
// Scoreboard bench for sqrt_restoring_seq: directed radicands with hand-computed roots.
module tb_sqrt_restoring_seq;

    localparam int unsigned ROOT_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rad;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] root;
    logic [16:0] rem;

    sqrt_restoring_seq #(
        .ROOT_W (ROOT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .rad_i       (rad),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .root_o      (root),
        .rem_o       (rem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rad;
        logic [15:0] root;
        logic [16:0] rem;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_in     = 0;
    int   n_out    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer happens on the edge after valid&&ready are seen here.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got root=%0d rem=%0d, required none", root, rem);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("root rad=%0d", e.rad), 64'(root), 64'(e.root));
                check($sformatf("rem rad=%0d", e.rad), 64'(rem), 64'(e.rem));
            end
            n_out++;
        end
    end

    // fr/fm: floor root and remainder; rr: rounded root.
    task automatic send(input logic [31:0] r, input logic [15:0] fr, input logic [16:0] fm,
                        input logic [15:0] rr, input bit push);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            timeout("in_ready_wait");
            return;
        end
        in_valid = 1'b1;
        rad      = r;
        tick();
        in_valid = 1'b0;
        if (push) begin
            e.rad = r;
            e.rem = fm;
`ifdef SQRT_ROUND_EN
            e.root = rr;
`else
            e.root = fr;
`endif
            sb.push_back(e);
            n_in++;
        end
    endtask

    task automatic release_result();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            timeout("out_valid_wait");
            return;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Called right after the accept edge; checks busy flags and exact latency.
    task automatic latency_check(input string name);
        for (int i = 1; i <= int'(ROOT_W); i++) begin
            tick();
            if (i == 1) check({name, "_busy_ready"}, 64'(in_ready), 64'd0);
            if (i == int'(ROOT_W) - 1) check({name, "_valid_early"}, 64'(out_valid), 64'd0);
            if (i == int'(ROOT_W)) begin
                check({name, "_valid_at_latency"}, 64'(out_valid), 64'd1);
                check({name, "_done_ready"}, 64'(in_ready), 64'd0);
            end
        end
    endtask

    logic [31:0] b2b_rad  [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd99, 32'd65536, 32'd10000,
                                  32'd123456789};
    logic [15:0] b2b_root [8] = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd9, 16'd256, 16'd100, 16'd11111};
    logic [16:0] b2b_rem  [8] = '{17'd0, 17'd1, 17'd2, 17'd0, 17'd18, 17'd0, 17'd0, 17'd2468};
    logic [15:0] b2b_rnd  [8] = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd10, 16'd256, 16'd100, 16'd11111};

    initial begin
        logic [15:0] held_root;
        logic [16:0] held_rem;
        bit          stable;
        bit          quiet;
        int          target;

        rst       = 1'b1;
        in_valid  = 1'b0;
        rad       = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_root", 64'(root), 64'd0);
        check("reset_rem", 64'(rem), 64'd0);
        rst = 1'b0;
        tick();

        // rad=0 with exact latency, then backpressure for 10 cycles.
        send(32'd0, 16'd0, 17'd0, 16'd0, 1'b1);
        latency_check("zero");
        held_root = root;
        held_rem  = rem;
        stable    = 1'b1;
        in_valid  = 1'b1;
        rad       = 32'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (root !== held_root || rem !== held_rem || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        check("backpressure_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);

        send(32'd1000000, 16'd1000, 17'd0, 16'd1000, 1'b1);
        latency_check("million");
        release_result();
        send(32'd17, 16'd4, 17'd1, 16'd4, 1'b1);
        latency_check("seventeen");
        release_result();

        send(32'hFFFFFFFF, 16'd65535, 17'd131070, 16'd65535, 1'b1);
        release_result();
        send(32'hFFFE0001, 16'd65535, 17'd0, 16'd65535, 1'b1);
        release_result();
        send(32'd20, 16'd4, 17'd4, 16'd4, 1'b1);
        release_result();
        send(32'd21, 16'd4, 17'd5, 16'd5, 1'b1);
        release_result();

        // Reset lands on the 7th iteration edge; the in-flight result must vanish.
        send(32'd999, 16'd31, 17'd38, 16'd32, 1'b0);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        check("midreset_no_result", 64'(quiet), 64'd1);
        send(32'd144, 16'd12, 17'd0, 16'd12, 1'b1);
        release_result();

        // Back-to-back operands with a randomly toggling consumer.
        target = n_in + 8;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(b2b_rad[i], b2b_root[i], b2b_rem[i], b2b_rnd[i], 1'b1);
            end
            begin
                int c;
                c = 0;
                while (n_out < target && c < 5000) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                    c++;
                end
                out_ready = 1'b0;
            end
        join
        if (n_out < target) timeout("b2b_drain");

        repeat (3) tick();
        check("results_vs_accepts", 64'(n_out), 64'(n_in));
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
